// File: rtl/warp_scheduler_pkg.sv
// Shared types and constants for the SIMT warp scheduler and its arbiter.
package gpu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        ISSUED,
        STALLED,
        DONE
    } warp_state_t;

    localparam int unsigned PERF_CNT_W = 32;

    function automatic int unsigned warp_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational cyclic-priority picker: first requester at or after ptr_i.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o
);

    logic [IDW-1:0] idx;

    // N is a power of two, so the IDW-bit add wraps the search cyclically.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr_i + IDW'(k);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = idx;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Warp scheduler: per-warp state/PC tracking, round-robin issue, stall penalty.
// Optional performance counters are built when WARP_SCHED_PERF_EN is defined.
module warp_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int unsigned NUM_WARPS     = 4,
    parameter int unsigned PC_BITS       = 8,
    parameter int unsigned STALL_PENALTY = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         launch,
    input  logic [NUM_WARPS-1:0]         launch_mask,
    input  logic [PC_BITS-1:0]           start_pc,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [$clog2(NUM_WARPS)-1:0] issue_warp_id,
    output logic [PC_BITS-1:0]           issue_pc,
    input  logic                         retire_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] retire_warp_id,
    input  logic [PC_BITS-1:0]           retire_next_pc,
    input  logic                         retire_stall,
    input  logic                         retire_exit,
    output logic [NUM_WARPS-1:0]         warp_done_mask,
    output logic                         all_done,
    output logic                         retire_err,
    output logic [PERF_CNT_W-1:0]        perf_issue_count,
    output logic [PERF_CNT_W-1:0]        perf_stall_cycles
);

    localparam int unsigned IDW   = warp_id_w(NUM_WARPS);
    localparam int unsigned CNT_W = $clog2(STALL_PENALTY + 1);

    warp_state_t        state_q [NUM_WARPS];
    warp_state_t        state_d [NUM_WARPS];
    logic [PC_BITS-1:0] pc_q    [NUM_WARPS];
    logic [PC_BITS-1:0] pc_d    [NUM_WARPS];
    logic [CNT_W-1:0]   cnt_q   [NUM_WARPS];
    logic [CNT_W-1:0]   cnt_d   [NUM_WARPS];
    logic [IDW-1:0]     rr_q, rr_d;
    logic               launched_q, launched_d;
    logic               err_q, err_d;

    logic [NUM_WARPS-1:0] ready_vec, quiet_vec, done_vec, stalled_vec;
    logic                 gnt_valid;
    logic [IDW-1:0]       gnt_id;
    logic                 handshake, launch_accept, retire_ok;

    always_comb begin
        ready_vec   = '0;
        quiet_vec   = '0;
        done_vec    = '0;
        stalled_vec = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            ready_vec[w]   = (state_q[w] == READY);
            done_vec[w]    = (state_q[w] == DONE);
            stalled_vec[w] = (state_q[w] == STALLED);
            quiet_vec[w]   = (state_q[w] == IDLE) || (state_q[w] == DONE);
        end
    end

    rr_arbiter #(
        .N   (NUM_WARPS),
        .IDW (IDW)
    ) u_arb (
        .req_i       (ready_vec),
        .ptr_i       (rr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign issue_valid    = enable && gnt_valid;
    assign issue_warp_id  = issue_valid ? gnt_id : '0;
    assign issue_pc       = issue_valid ? pc_q[gnt_id] : '0;
    assign handshake      = issue_valid && issue_ready;
    assign launch_accept  = launch && (&quiet_vec);
    assign retire_ok      = retire_valid && (state_q[retire_warp_id] == ISSUED);
    assign warp_done_mask = done_vec;
    assign all_done       = launched_q && (&quiet_vec);
    assign retire_err     = err_q;

    // Handshake and accepted retire always target different warps (READY vs ISSUED).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        launched_d = launched_q;
        err_d      = err_q || (retire_valid && !retire_ok);
        if (launch_accept) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                cnt_d[w] = '0;
                if (launch_mask[w]) begin
                    state_d[w] = READY;
                    pc_d[w]    = start_pc;
                end else begin
                    state_d[w] = IDLE;
                end
            end
            launched_d = 1'b1;
            rr_d       = '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                if (stalled_vec[w] && enable) begin
                    if (cnt_q[w] <= CNT_W'(1)) begin
                        cnt_d[w]   = '0;
                        state_d[w] = READY;
                    end else begin
                        cnt_d[w] = cnt_q[w] - CNT_W'(1);
                    end
                end
            end
            if (handshake) begin
                state_d[gnt_id] = ISSUED;
                rr_d            = gnt_id + IDW'(1);
            end
            if (retire_ok) begin
                if (retire_exit) begin
                    state_d[retire_warp_id] = DONE;
                end else if (retire_stall) begin
                    state_d[retire_warp_id] = STALLED;
                    cnt_d[retire_warp_id]   = CNT_W'(STALL_PENALTY);
                    pc_d[retire_warp_id]    = retire_next_pc;
                end else begin
                    state_d[retire_warp_id] = READY;
                    pc_d[retire_warp_id]    = retire_next_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
                pc_q[w]    <= '0;
                cnt_q[w]   <= '0;
            end
            rr_q       <= '0;
            launched_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            launched_q <= launched_d;
            err_q      <= err_d;
        end
    end

`ifdef WARP_SCHED_PERF_EN
    localparam int unsigned NST_W = IDW + 1;

    logic [PERF_CNT_W-1:0] perf_iss_q, perf_stall_q;
    logic [PERF_CNT_W:0]   iss_sum, stall_sum;
    logic [NST_W-1:0]      n_stalled;

    always_comb begin
        n_stalled = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            n_stalled = n_stalled + NST_W'(stalled_vec[w]);
        end
        iss_sum   = {1'b0, perf_iss_q} + (PERF_CNT_W + 1)'(handshake);
        stall_sum = {1'b0, perf_stall_q} + (enable ? (PERF_CNT_W + 1)'(n_stalled) : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_iss_q   <= '0;
            perf_stall_q <= '0;
        end else if (launch_accept) begin
            perf_iss_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_iss_q   <= iss_sum[PERF_CNT_W]   ? '1 : iss_sum[PERF_CNT_W-1:0];
            perf_stall_q <= stall_sum[PERF_CNT_W] ? '1 : stall_sum[PERF_CNT_W-1:0];
        end
    end

    assign perf_issue_count  = perf_iss_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_issue_count  = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: vector table, directed sequences, random vs reference model.
module tb_warp_scheduler;

    localparam int NW  = 4;
    localparam int PEN = 3;
    localparam int S_IDLE = 0, S_READY = 1, S_ISSUED = 2, S_STALLED = 3, S_DONE = 4;

    logic        clk = 1'b0;
    logic        reset, enable, launch, issue_ready;
    logic [3:0]  launch_mask;
    logic [7:0]  start_pc, retire_next_pc;
    logic        retire_valid, retire_stall, retire_exit;
    logic [1:0]  retire_warp_id;
    logic        issue_valid, all_done, retire_err;
    logic [1:0]  issue_warp_id;
    logic [7:0]  issue_pc;
    logic [3:0]  warp_done_mask;
    logic [31:0] perf_issue_count, perf_stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    warp_scheduler #(
        .NUM_WARPS     (NW),
        .PC_BITS       (8),
        .STALL_PENALTY (PEN)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .launch            (launch),
        .launch_mask       (launch_mask),
        .start_pc          (start_pc),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_warp_id     (issue_warp_id),
        .issue_pc          (issue_pc),
        .retire_valid      (retire_valid),
        .retire_warp_id    (retire_warp_id),
        .retire_next_pc    (retire_next_pc),
        .retire_stall      (retire_stall),
        .retire_exit       (retire_exit),
        .warp_done_mask    (warp_done_mask),
        .all_done          (all_done),
        .retire_err        (retire_err),
        .perf_issue_count  (perf_issue_count),
        .perf_stall_cycles (perf_stall_cycles)
    );

    // Reference model: spec-level warp bookkeeping.
    int              mst  [NW];
    int              mpc  [NW];
    int              mcnt [NW];
    int              mrr;
    bit              mlaunched, merr;
    longint unsigned mperf_iss, mperf_stall;
    int              cand[$];

    typedef struct {
        bit       launch;
        bit [3:0] mask;
        bit [7:0] spc;
        bit       ready;
        bit       ev;
        int       eid;
        bit [7:0] epc;
        bit       eall;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msel();
        for (int k = 0; k < NW; k++) begin
            if (mst[(mrr + k) % NW] == S_READY) return (mrr + k) % NW;
        end
        return -1;
    endfunction

    function automatic longint unsigned sat32(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    function automatic bit mquiet();
        for (int w = 0; w < NW; w++) begin
            if (mst[w] != S_IDLE && mst[w] != S_DONE) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            mst[w] = S_IDLE; mpc[w] = 0; mcnt[w] = 0;
        end
        mrr = 0; mlaunched = 0; merr = 0; mperf_iss = 0; mperf_stall = 0;
    endtask

    task automatic model_check();
        int       sel;
        bit       ev;
        bit [3:0] dm;
        sel = msel();
        ev  = enable && (sel >= 0);
        chk("issue_valid", issue_valid, ev);
        if (ev) begin
            chk("issue_warp_id", issue_warp_id, sel);
            chk("issue_pc", issue_pc, mpc[sel]);
        end
        dm = '0;
        for (int w = 0; w < NW; w++) dm[w] = (mst[w] == S_DONE);
        chk("warp_done_mask", warp_done_mask, dm);
        chk("all_done", all_done, mlaunched && mquiet());
        chk("retire_err", retire_err, merr);
`ifdef WARP_SCHED_PERF_EN
        chk("perf_issue_count", perf_issue_count, mperf_iss);
        chk("perf_stall_cycles", perf_stall_cycles, mperf_stall);
`else
        chk("perf_issue_off", perf_issue_count, 0);
        chk("perf_stall_off", perf_stall_cycles, 0);
`endif
    endtask

    task automatic model_step();
        int old[NW];
        int sel, nst, rid;
        bit quiet;
        old   = mst;
        quiet = mquiet();
        sel   = msel();
        rid   = int'(retire_warp_id);
        if (retire_valid && old[rid] != S_ISSUED) merr = 1;
        if (launch && quiet) begin
            for (int w = 0; w < NW; w++) begin
                mst[w] = launch_mask[w] ? S_READY : S_IDLE;
                if (launch_mask[w]) mpc[w] = int'(start_pc);
            end
            mlaunched = 1; mrr = 0; mperf_iss = 0; mperf_stall = 0;
        end else begin
            if (enable) begin
                nst = 0;
                for (int w = 0; w < NW; w++) begin
                    if (old[w] == S_STALLED) begin
                        nst++;
                        mcnt[w]--;
                        if (mcnt[w] == 0) mst[w] = S_READY;
                    end
                end
                mperf_stall = sat32(mperf_stall + nst);
            end
            if (enable && issue_ready && sel >= 0) begin
                mst[sel]  = S_ISSUED;
                mrr       = (sel + 1) % NW;
                mperf_iss = sat32(mperf_iss + 1);
            end
            if (retire_valid && old[rid] == S_ISSUED) begin
                if (retire_exit) begin
                    mst[rid] = S_DONE;
                end else if (retire_stall) begin
                    mst[rid] = S_STALLED; mcnt[rid] = PEN; mpc[rid] = int'(retire_next_pc);
                end else begin
                    mst[rid] = S_READY; mpc[rid] = int'(retire_next_pc);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1; launch = 0; launch_mask = '0; start_pc = '0; issue_ready = 0;
        retire_valid = 0; retire_warp_id = '0; retire_next_pc = '0;
        retire_stall = 0; retire_exit = 0;
    endtask

    task automatic retire(input int id, input bit [7:0] npc, input bit st, input bit ex);
        retire_valid = 1; retire_warp_id = id[1:0]; retire_next_pc = npc;
        retire_stall = st; retire_exit = ex;
    endtask

    task automatic no_retire();
        retire_valid = 0; retire_stall = 0; retire_exit = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, issue_valid, 0);
        chk({tag, "_id"}, issue_warp_id, 0);
        chk({tag, "_pc"}, issue_pc, 0);
        chk({tag, "_done_mask"}, warp_done_mask, 0);
        chk({tag, "_all_done"}, all_done, 0);
        chk({tag, "_err"}, retire_err, 0);
        chk({tag, "_perf_iss"}, perf_issue_count, 0);
        chk({tag, "_perf_stall"}, perf_stall_cycles, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic expect_issue(input string tag, input bit v, input int id, input bit [7:0] pc);
        chk({tag, "_valid"}, issue_valid, v);
        if (v) begin
            chk({tag, "_id"}, issue_warp_id, id);
            chk({tag, "_pc"}, issue_pc, pc);
        end
    endtask

    initial begin
        do_reset();

        // Vector table: launch all four and drain them in order.
        tbl[0] = '{1'b1, 4'hF, 8'h10, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 0, 8'h10, 1'b0};
        tbl[2] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1, 8'h10, 1'b0};
        tbl[3] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 2, 8'h10, 1'b0};
        tbl[4] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 3, 8'h10, 1'b0};
        tbl[5] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        for (int i = 0; i < 6; i++) begin
            launch = tbl[i].launch; launch_mask = tbl[i].mask;
            start_pc = tbl[i].spc; issue_ready = tbl[i].ready;
            #1;
            expect_issue($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eid, tbl[i].epc);
            chk($sformatf("tbl%0d_all_done", i), all_done, tbl[i].eall);
            tick();
        end

        // Retire of warp 2 alongside warp 3's handshake.
        do_reset();
        launch = 1; launch_mask = 4'hF; start_pc = 8'h10; tick();
        launch = 0; issue_ready = 1;
        repeat (3) tick();
        expect_issue("pre_a", 1, 3, 8'h10);
        retire(2, 8'h14, 0, 0); tick();
        no_retire();
        expect_issue("seq_a", 1, 2, 8'h14);

        // Stall penalty on warp 1 while warp 2 is handshaked.
        retire(1, 8'h20, 1, 0); tick();
        no_retire(); issue_ready = 0;
        expect_issue("stall0", 0, 0, 0);
        tick(); expect_issue("stall1", 0, 0, 0);
        tick(); expect_issue("stall2", 0, 0, 0);
        tick(); expect_issue("stall_end", 1, 1, 8'h20);
`ifdef WARP_SCHED_PERF_EN
        chk("stall_perf", perf_stall_cycles, 3);
        chk("issue_perf", perf_issue_count, 5);
`endif

        // Backpressure with warps 0 and 2 READY, pointer at 0.
        issue_ready = 1; retire(3, 8'h30, 0, 0); tick();
        expect_issue("bp_w3", 1, 3, 8'h30);
        retire(0, 8'h40, 0, 0); tick();
        issue_ready = 0; retire(2, 8'h50, 0, 0); tick();
        no_retire();
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_issue($sformatf("bp_hold%0d", i), 1, 0, 8'h40);
        end
        issue_ready = 1; tick();
        expect_issue("bp_then2", 1, 2, 8'h50);
        tick();
        expect_issue("bp_empty", 0, 0, 0);
        issue_ready = 0;

        // Retire to a READY warp is a sticky error and changes nothing.
        retire(0, 8'h60, 0, 0); tick();
        chk("err_before", retire_err, 0);
        retire(0, 8'h99, 0, 0); tick();
        no_retire();
        chk("err_set", retire_err, 1);
        expect_issue("err_unchanged", 1, 0, 8'h60);
        repeat (2) tick();
        chk("err_sticky", retire_err, 1);

        // Exit all warps, then relaunch a single warp.
        issue_ready = 1; tick(); issue_ready = 0;
        for (int w = 0; w < NW; w++) begin
            retire(w, 8'h00, 1, 1); tick();
        end
        no_retire();
        chk("exit_mask", warp_done_mask, 4'hF);
        chk("exit_all_done", all_done, 1);
        launch = 1; launch_mask = 4'b0001; start_pc = 8'h70; tick();
        chk("relaunch_all_done", all_done, 0);
        chk("relaunch_mask", warp_done_mask, 0);
        expect_issue("relaunch", 1, 0, 8'h70);

        // Launch while busy is ignored.
        launch_mask = 4'b1110; start_pc = 8'h80; tick();
        launch = 0;
        expect_issue("busy_launch", 1, 0, 8'h70);
        issue_ready = 1; tick(); issue_ready = 0;
        expect_issue("busy_launch_no_w1", 0, 0, 0);
        chk("busy_launch_err", retire_err, 1);

        // Asynchronous reset in the middle of a stall.
        retire(0, 8'h88, 1, 0); tick();
        no_retire();
        #2 reset = 1;
        #1 check_zero("mid_reset");
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1 reset = 0;

        // Empty launch mask completes immediately.
        launch = 1; launch_mask = 4'h0; tick();
        launch = 0;
        chk("zero_mask_all_done", all_done, 1);
        chk("zero_mask_valid", issue_valid, 0);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            enable      = ($urandom_range(0, 9) != 0);
            issue_ready = ($urandom_range(0, 3) != 0);
            launch      = ($urandom_range(0, 19) == 0);
            launch_mask = 4'($urandom_range(0, 15));
            start_pc    = 8'($urandom_range(0, 255));
            no_retire();
            if ($urandom_range(0, 2) != 0) begin
                cand.delete();
                for (int w = 0; w < NW; w++) if (mst[w] == S_ISSUED) cand.push_back(w);
                retire_next_pc = 8'($urandom_range(0, 255));
                retire_stall   = ($urandom_range(0, 3) == 0);
                retire_exit    = ($urandom_range(0, 6) == 0);
                if (cand.size() > 0 && $urandom_range(0, 19) != 0) begin
                    retire_valid   = 1;
                    retire_warp_id = 2'(cand[$urandom_range(0, cand.size() - 1)]);
                end else if ($urandom_range(0, 9) == 0) begin
                    retire_valid   = 1;
                    retire_warp_id = 2'($urandom_range(0, 3));
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Issues instructions from NUM_WARPS resident warps into the shared SIMT pipeline (fetch, decode, branch divergence unit) one warp per handshake.
- Tracks a per-warp state and PC, and applies a fixed penalty when the divergence unit reports a stall.
- Sits between the kernel launch logic and the core front end.

Parameters:
NUM_WARPS, 4, resident warps (≥2, power of two)
PC_BITS, 8, program counter width
STALL_PENALTY, 3, cycles a warp waits after a divergence stall (≥1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
enable  input  1  scheduling enable
launch  input  1  start-kernel pulse
launch_mask  input  NUM_WARPS  warps to start
start_pc  input  PC_BITS  initial PC for launched warps
issue_valid  output  1  a warp is offered
issue_ready  input  1  pipeline accepts the offer
issue_warp_id  output  $clog2(NUM_WARPS)  offered warp
issue_pc  output  PC_BITS  PC of offered warp
retire_valid  input  1  an issued instruction has completed
retire_warp_id  input  $clog2(NUM_WARPS)  completing warp
retire_next_pc  input  PC_BITS  next PC from the divergence unit
retire_stall  input  1  divergence unit asserted stall
retire_exit  input  1  warp executed exit
warp_done_mask  output  NUM_WARPS  warps in DONE
all_done  output  1  launched kernel finished
retire_err  output  1  sticky protocol error
perf_issue_count  output  32  issue handshakes (optional feature)
perf_stall_cycles  output  32  warp-cycles spent in STALLED (optional feature)

Behaviour:
- Reset:
  - All warps go to IDLE with pc=0, rr pointer=0, launched=0.
  - All outputs read 0.
- Per-warp FSM transitions:
  - IDLE→READY: on an accepted launch with the warp's launch_mask bit set.
  - READY→ISSUED: on an issue handshake for this warp.
  - ISSUED→DONE: on retire with retire_exit=1.
  - ISSUED→STALLED: on retire with retire_stall=1. Load counter=STALL_PENALTY and pc=retire_next_pc.
  - ISSUED→READY: on any other retire. pc=retire_next_pc.
  - STALLED→READY: when the counter reaches 0. The counter decrements only while enable=1.
  - DONE→READY: on an accepted relaunch only.
- Retire priority: retire_exit has priority over retire_stall.
- Launch acceptance:
  - Launch is accepted only when every warp is IDLE or DONE.
  - On acceptance: masked warps go to READY, unmasked warps go to IDLE, launched=1, rr pointer=0.
  - A launch while busy is ignored and sets no error.
  - launch_mask=0 is accepted: all_done=1 on the next cycle.
- Issue (combinational from registered state):
  - issue_valid=enable && any warp READY.
  - issue_warp_id is the first READY warp at or after the rr pointer, searching cyclically.
  - issue_pc is that warp's pc.
  - Handshake = issue_valid && issue_ready. On handshake, the rr pointer becomes (id+1) mod NUM_WARPS.
  - Without a handshake, the selection is unchanged next cycle unless a new READY warp appears ahead of it in rr order.
- Retire rules:
  - A retire is accepted even when enable=0.
  - A retire for a warp not in ISSUED is ignored and sets retire_err. retire_err clears only on reset.
  - A warp made READY by a retire first becomes eligible the following cycle.
  - Retire of one warp and issue of another in the same cycle both take effect.
- Status outputs:
  - warp_done_mask is registered state decode.
  - all_done = launched && every warp IDLE or DONE.
  - all_done falls on the cycle after an accepted relaunch that starts at least one warp.
- Reset mid-operation: asynchronously returns everything to reset state. In-flight retires are lost.
- PC arithmetic: no PC arithmetic is done here; PCs are stored and forwarded only.

Optional Feature:
- Macro WARP_SCHED_PERF_EN.
- Defined:
  - perf_issue_count increments per handshake.
  - perf_stall_cycles adds the number of warps in STALLED each enabled cycle.
  - Both counters saturate at all-ones, clear on reset and on accepted launch.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package gpu_sched_pkg:
  - warp_state_t enum {IDLE, READY, ISSUED, STALLED, DONE}
  - WARP_ID_W function/constant
  - perf counter width constant 32
- Sub-module rr_arbiter: combinational cyclic priority picker. Inputs are a NUM_WARPS request vector and the pointer. Outputs are grant valid and id. It is reused by future LSU arbitration.

Test Plan:
- Launch mask 4'b1111, start_pc=8'h10, issue_ready=1, no retires → ids issue 0,1,2,3, each with pc 8'h10, then issue_valid=0.
- Warp 2 retires next_pc=8'h14 (no stall) while warp 3 is offered → warp 3 handshakes; warp 2 is offered next with pc 8'h14.
- Retire warp 1 with retire_stall=1, STALL_PENALTY=3 → warp 1 is not offered for 3 enabled cycles, then is offered with the retired next_pc. perf_stall_cycles=3 with macro defined.
- Hold issue_ready=0 for 5 cycles with warps 0,2 READY → issue_valid stays 1 and id/pc stay stable; after release, 0 is issued then 2.
- Retire warp 0 while it is READY → retire_err=1 and stays 1; warp 0 state is unchanged.
- Retire_exit for all 4 warps → warp_done_mask=4'b1111, all_done=1. Relaunch with mask 4'b0001 → all_done=0 next cycle.
- Launch while warps are busy → launch is ignored.
- Assert reset mid-stall → all outputs 0 immediately.
